// File: rtl/seg7_pkg.sv
// seg7_pkg
// Definitions shared by the 7-segment driver and receiver blocks:
//   - segment bit positions SEG_A..SEG_G (bit0 = a ... bit6 = g, active-high)
//   - the sixteen hex glyph patterns, plus glyph_of() to fetch one by code
//   - the receiver frame FSM state encoding
package seg7_pkg;

    localparam int SEG_A = 0;
    localparam int SEG_B = 1;
    localparam int SEG_C = 2;
    localparam int SEG_D = 3;
    localparam int SEG_E = 4;
    localparam int SEG_F = 5;
    localparam int SEG_G = 6;

    localparam logic [6:0] GLYPH_0 = 7'h3F;
    localparam logic [6:0] GLYPH_1 = 7'h06;
    localparam logic [6:0] GLYPH_2 = 7'h5B;
    localparam logic [6:0] GLYPH_3 = 7'h4F;
    localparam logic [6:0] GLYPH_4 = 7'h66;
    localparam logic [6:0] GLYPH_5 = 7'h6D;
    localparam logic [6:0] GLYPH_6 = 7'h7D;
    localparam logic [6:0] GLYPH_7 = 7'h07;
    localparam logic [6:0] GLYPH_8 = 7'h7F;
    localparam logic [6:0] GLYPH_9 = 7'h6F;
    localparam logic [6:0] GLYPH_A = 7'h77;
    localparam logic [6:0] GLYPH_B = 7'h7C;
    localparam logic [6:0] GLYPH_C = 7'h39;
    localparam logic [6:0] GLYPH_D = 7'h5E;
    localparam logic [6:0] GLYPH_E = 7'h79;
    localparam logic [6:0] GLYPH_F = 7'h71;

    typedef enum logic [1:0] {
        S_FIRST = 2'd0,
        S_EMPTY = 2'd1,
        S_FULL  = 2'd2
    } frame_state_e;

    function automatic logic [6:0] glyph_of(input logic [3:0] code);
        case (code)
            4'h0:    return GLYPH_0;
            4'h1:    return GLYPH_1;
            4'h2:    return GLYPH_2;
            4'h3:    return GLYPH_3;
            4'h4:    return GLYPH_4;
            4'h5:    return GLYPH_5;
            4'h6:    return GLYPH_6;
            4'h7:    return GLYPH_7;
            4'h8:    return GLYPH_8;
            4'h9:    return GLYPH_9;
            4'hA:    return GLYPH_A;
            4'hB:    return GLYPH_B;
            4'hC:    return GLYPH_C;
            4'hD:    return GLYPH_D;
            4'hE:    return GLYPH_E;
            default: return GLYPH_F;
        endcase
    endfunction

endpackage

// File: rtl/seg7_glyph_decode.sv
// seg7_glyph_decode
// Combinational reverse lookup of a segment pattern against the hex glyph set.
// Ports:
//   pattern  in  7  active-high segment pattern (bit0 = a ... bit6 = g)
//   known    out 1  pattern is one of the sixteen glyphs
//   code     out 4  glyph value 0..F, 0 when the pattern is not a glyph
module seg7_glyph_decode
    import seg7_pkg::*;
(
    input  logic [6:0] pattern,
    output logic       known,
    output logic [3:0] code
);

    // Glyph patterns are all distinct, so at most one entry can match.
    always_comb begin
        known = 1'b0;
        code  = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (pattern == glyph_of(4'(i))) begin
                known = 1'b1;
                code  = 4'(i);
            end
        end
    end

endmodule

// File: rtl/seg7_frame_decoder.sv
// seg7_frame_decoder
// Watches the seven segment lines of a display, filters glitches, and hands each
// new stable pattern (a "frame") to a consumer together with its decoded glyph
// and the number of clock cycles since the previous frame.
// Ports:
//   clk           in   1         system clock
//   reset         in   1         asynchronous active-high reset
//   segments_in   in   7         segment lines, bit0 = a ... bit6 = g
//   frame_valid   out  1         a frame is held for the consumer
//   frame_ready   in   1         consumer takes the frame when high with frame_valid
//   frame_seg     out  7         accepted segment pattern (active-high)
//   frame_code    out  4         decoded hex glyph, 0 when unknown
//   frame_known   out  1         frame_seg is one of the sixteen glyphs
//   frame_period  out  PERIOD_W  cycles since the previous frame, 0 for the first
//   overrun       out  1         sticky: a frame was dropped while output was full
// Build option: define SEG7_ACTIVE_LOW_EN for common-anode boards; the lines are
// then inverted at the input register and everything downstream is active-high.
module seg7_frame_decoder
    import seg7_pkg::*;
#(
    parameter int STABLE_CYCLES = 4,
    parameter int PERIOD_W      = 24
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [6:0]          segments_in,
    output logic                frame_valid,
    input  logic                frame_ready,
    output logic [6:0]          frame_seg,
    output logic [3:0]          frame_code,
    output logic                frame_known,
    output logic [PERIOD_W-1:0] frame_period,
    output logic                overrun
);

    localparam logic [7:0]          STABLE_MAX = 8'(STABLE_CYCLES);
    localparam logic [PERIOD_W-1:0] PERIOD_MAX = '1;

    frame_state_e        state_q, state_d;
    logic [6:0]          sample_q, sample_d;
    logic [6:0]          prev_q, prev_d;
    logic [7:0]          stable_q, stable_d;
    logic [6:0]          last_q, last_d;
    logic [PERIOD_W-1:0] period_cnt_q, period_cnt_d;
    logic [6:0]          frame_seg_q, frame_seg_d;
    logic [PERIOD_W-1:0] frame_period_q, frame_period_d;
    logic                overrun_q, overrun_d;

    logic                accept;
    logic                load;
    logic                drop;
    logic [PERIOD_W-1:0] period_next;

    // Input register, previous-sample register and saturating stability count.
    always_comb begin
`ifdef SEG7_ACTIVE_LOW_EN
        sample_d = ~segments_in;
`else
        sample_d = segments_in;
`endif
        prev_d = sample_q;
        if (sample_q == prev_q) begin
            stable_d = (stable_q == STABLE_MAX) ? stable_q : stable_q + 8'd1;
        end else begin
            stable_d = 8'd0;
        end
    end

    // Acceptance fires only on the transition into a full count, so a held
    // pattern cannot fire twice; it must also be new compared to the last one.
    assign accept = (sample_q == prev_q)
                 && (stable_q == STABLE_MAX - 8'd1)
                 && ((state_q == S_FIRST) || (sample_q != last_q));

    assign period_next = (period_cnt_q == PERIOD_MAX) ? PERIOD_MAX
                                                      : period_cnt_q + PERIOD_W'(1);

    // Frame FSM: decides whether an accepted pattern is loaded or dropped.
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        drop    = 1'b0;
        case (state_q)
            S_FIRST, S_EMPTY: begin
                if (accept) begin
                    state_d = S_FULL;
                    load    = 1'b1;
                end
            end
            S_FULL: begin
                if (accept) begin
                    if (frame_ready) begin
                        load = 1'b1;
                    end else begin
                        drop = 1'b1;
                    end
                end else if (frame_ready) begin
                    state_d = S_EMPTY;
                end
            end
            default: state_d = S_FIRST;
        endcase
    end

    // Even a dropped frame becomes the new reference pattern and restarts the
    // dwell count, so the next reported period measures from it.
    always_comb begin
        last_d         = accept ? sample_q : last_q;
        period_cnt_d   = accept ? '0 : period_next;
        frame_seg_d    = load ? sample_q : frame_seg_q;
        frame_period_d = frame_period_q;
        if (load) begin
            frame_period_d = (state_q == S_FIRST) ? '0 : period_next;
        end
        overrun_d = overrun_q | drop;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_FIRST;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sample_q       <= '0;
            prev_q         <= '0;
            stable_q       <= '0;
            last_q         <= '0;
            period_cnt_q   <= '0;
            frame_seg_q    <= '0;
            frame_period_q <= '0;
            overrun_q      <= 1'b0;
        end else begin
            sample_q       <= sample_d;
            prev_q         <= prev_d;
            stable_q       <= stable_d;
            last_q         <= last_d;
            period_cnt_q   <= period_cnt_d;
            frame_seg_q    <= frame_seg_d;
            frame_period_q <= frame_period_d;
            overrun_q      <= overrun_d;
        end
    end

    seg7_glyph_decode u_glyph_decode (
        .pattern (frame_seg_q),
        .known   (frame_known),
        .code    (frame_code)
    );

    assign frame_valid  = (state_q == S_FULL);
    assign frame_seg    = frame_seg_q;
    assign frame_period = frame_period_q;
    assign overrun      = overrun_q;

endmodule

// File: doc/seg7_frame_decoder.md
Name: seg7_frame_decoder

Overview:
Receive-side companion to the 7-segment animation driver: samples the 7 segment lines, rejects glitches, and detects each new stable display frame. Decodes each accepted frame to a hex glyph where possible and measures the frame dwell time in clock cycles. Delivers each frame on a valid/ready interface to a checker, a UART bridge or a self-test block.

Parameters:
STABLE_CYCLES, 4, consecutive identical samples required before a pattern is accepted as a frame (legal range 1..255)
PERIOD_W, 24, width of the dwell-time measurement; matches the 24-bit animation speed counter

Ports:
clk  in  1  system clock (10 MHz nominal)
reset  in  1  asynchronous, active-high reset
segments_in  in  7  segment lines, bit0=a … bit6=g, active-high
frame_valid  out  1  output frame held and available
frame_ready  in  1  consumer accepts the frame when high together with frame_valid
frame_seg  out  7  raw accepted segment pattern
frame_code  out  4  decoded hex glyph 0..F
frame_known  out  1  1 when frame_seg matches a glyph in the table
frame_period  out  PERIOD_W  clock cycles since the previous accepted frame; 0 for the first frame after reset
overrun  out  1  sticky: a frame was dropped because the output was still occupied

Behaviour:
- Reset (async assert, sync release):
  - frame_valid, overrun, frame_seg, frame_code, frame_known and frame_period are all 0.
  - The internal last-accepted pattern is marked empty.
  - The FSM goes to S_FIRST.
- Input path:
  - segments_in is registered once.
  - The stability counter increments while the registered sample equals the previous sample, saturating at STABLE_CYCLES; it clears to 0 on any change.
- Acceptance:
  - A pattern is accepted in the cycle its stability count reaches STABLE_CYCLES.
  - It must also differ from the last accepted pattern, or no pattern may have been accepted yet.
  - A steady pattern produces exactly one frame, no matter how long it is held.
- Latency: with a new pattern applied before edge 0 and held, frame_valid is high after edge STABLE_CYCLES+1.
- Glitch rejection: a pattern held for fewer than STABLE_CYCLES+1 sampled cycles never produces a frame. If the lines return to the last accepted pattern afterwards, no frame is produced either.
- Period counter:
  - Clears to 0 in each acceptance cycle, then increments every cycle.
  - On the next acceptance, frame_period = counter+1, saturating at 2^PERIOD_W-1.
  - In S_FIRST the counter is ignored and the reported period is 0.
- FSM:
  - S_FIRST: first acceptance → S_FULL.
  - S_EMPTY: acceptance → S_FULL.
  - S_FULL: handshake with no acceptance in the same cycle → S_EMPTY.
  - S_FULL with acceptance in the same cycle as the handshake → stays S_FULL and loads the new frame; no overrun.
  - S_FULL with acceptance and no handshake → keeps the old frame, drops the new one, sets overrun.
  - A dropped frame still updates the last-accepted pattern and restarts the period counter.
- Output stability: frame outputs are stable while frame_valid=1 and no handshake has occurred. frame_valid=1 exactly in S_FULL.
- Decode table (frame_seg → frame_code), all other patterns give frame_known=0, frame_code=0:
  - 3F→0, 06→1, 5B→2, 4F→3, 66→4, 6D→5, 7D→6, 07→7
  - 7F→8, 6F→9, 77→A, 7C→b, 39→C, 5E→d, 79→E, 71→F
- overrun clears only on reset.
- Reset asserted mid-frame discards everything immediately, including a pending frame and partial stability counts.

Optional Feature:
SEG7_ACTIVE_LOW_EN
- Defined: segments_in is inverted at the input register, to support common-anode boards. frame_seg reports the decoded active-high pattern.
- Undefined: no inversion.

Decomposition:
- Shared package seg7_pkg:
  - Segment bit index constants SEG_A..SEG_G.
  - The 16 glyph pattern constants, shared with the driver-side seg7 lookup.
  - FSM state encoding (S_FIRST, S_EMPTY, S_FULL, 2 bits).
- One natural sub-module: seg7_glyph_decode, a combinational pattern→{known, code} lookup instantiated once on the accepted pattern.
- Stability filter, period counter and FSM stay in the top.

Test Plan:
- Reset, then hold 3F with STABLE_CYCLES=4 and frame_ready=1 → frame_valid pulses once at edge 5 with frame_code=0, known=1, period=0. No further frames while 3F is held.
- Apply 3F, then 06 at 1000-cycle intervals with ready=1 → second frame has code=1 and period=1000.
- Apply a 3-cycle glitch to 7F between steady 06 windows → no frame emitted; the period still measures from the 06 acceptance.
- Hold ready=0, present 5B then 4F → first frame (5B) is retained, overrun=1. Raise ready → one handshake, then valid=0.
- Align a new acceptance with a handshake cycle → valid stays 1 and the new frame replaces the old; overrun stays 0.
- Present unknown pattern 49, then assert reset mid-count → frame has known=0, code=0. After reset all outputs are 0 and the next frame reports period=0.
